// File: rtl/simon_pkg.sv
// Shared Simon definitions: colour encoding, sequencer states and the common
// timer loads used by game control, input timeout and playback.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM_ON,
    S_SHOW,
    S_ARM_OFF,
    S_GAP,
    S_DONE
  } seq_state_t;

  localparam logic [24:0] SIMON_ON_LOAD  = 25'd12_500_000;
  localparam logic [24:0] SIMON_OFF_LOAD = 25'd6_250_000;

  function automatic logic [3:0] color_onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/playback_sequencer.sv
// Plays the stored colour pattern on the LEDs by sequencing the shared
// countdown timer through alternating ON and OFF phases.
module playback_sequencer
  import simon_pkg::*;
#(
  parameter int                LOAD_W   = 25,
  parameter logic [LOAD_W-1:0] ON_LOAD  = LOAD_W'(SIMON_ON_LOAD),
  parameter logic [LOAD_W-1:0] OFF_LOAD = LOAD_W'(SIMON_OFF_LOAD),
  parameter int                MAX_LEN  = 16,
  localparam int               ADDR_W   = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [1:0]        pat_data,
  output logic [LOAD_W-1:0] tmr_load,
  output logic              tmr_reset,
  output logic              tmr_enable,
  input  logic              tmr_pulse,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);

  seq_state_t        state, state_n;
  logic [ADDR_W:0]   idx, idx_n, len, len_n, len_clamp;
  logic [ADDR_W-1:0] pat_addr_n;
  logic [LOAD_W-1:0] tmr_load_n;
  logic              tmr_reset_n, tmr_enable_n, busy_n, done_n;
  logic [3:0]        led_n;

  assign len_clamp = (length > LEN_MAX) ? LEN_MAX : length;

  // Outputs are registered: next-state logic also computes the output values
  // belonging to the state being entered.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    len_n        = len;
    pat_addr_n   = pat_addr;
    tmr_load_n   = tmr_load;
    tmr_reset_n  = 1'b0;
    tmr_enable_n = tmr_enable;
    led_n        = led;
    busy_n       = busy;
    done_n       = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        len_n = len_clamp;
        idx_n = '0;
        if (len_clamp == '0) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          state_n      = S_ARM_ON;
          busy_n       = 1'b1;
          tmr_load_n   = ON_LOAD;
          tmr_reset_n  = 1'b1;
          tmr_enable_n = 1'b1;
          pat_addr_n   = '0;
        end
      end
      S_ARM_ON: begin
        state_n      = S_SHOW;
        led_n        = color_onehot(color_t'(pat_data));
        tmr_enable_n = 1'b1;
      end
      S_SHOW: if (tmr_pulse) begin
        led_n = '0;
        if (idx == len - 1'b1) begin
          state_n      = S_DONE;
          done_n       = 1'b1;
          tmr_enable_n = 1'b0;
        end else begin
          state_n     = S_ARM_OFF;
          tmr_load_n  = OFF_LOAD;
          tmr_reset_n = 1'b1;
          idx_n       = idx + 1'b1;
        end
      end
      S_ARM_OFF: state_n = S_GAP;
      S_GAP: if (tmr_pulse) begin
        state_n     = S_ARM_ON;
        tmr_load_n  = ON_LOAD;
        tmr_reset_n = 1'b1;
        pat_addr_n  = idx[ADDR_W-1:0];
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      len        <= '0;
      pat_addr   <= '0;
      tmr_load   <= '0;
      tmr_reset  <= 1'b0;
      tmr_enable <= 1'b0;
      led        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      len        <= len_n;
      pat_addr   <= pat_addr_n;
      tmr_load   <= tmr_load_n;
      tmr_reset  <= tmr_reset_n;
      tmr_enable <= tmr_enable_n;
      led        <= led_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
// Scoreboard bench for playback_sequencer with a behavioural timer and a
// four-entry pattern memory {2,0,3,1} repeated across the address space.
module tb_playback_sequencer;
  import simon_pkg::*;

  localparam int LOAD_W = 25;
  localparam int ON_L   = 3;
  localparam int OFF_L  = 2;
  localparam int MAXL   = 16;
  localparam int AW     = 4;

  typedef struct packed {
    logic [3:0]    led;
    logic [AW-1:0] addr;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [AW:0]       length = '0;
  logic [AW-1:0]     pat_addr;
  logic [1:0]        pat_data;
  logic [LOAD_W-1:0] tmr_load;
  logic              tmr_reset, tmr_enable, tmr_pulse;
  logic [3:0]        led;
  logic              busy, done;

  logic [LOAD_W-1:0] cnt = '0;
  logic              force_pulse = 1'b0;
  logic [1:0]        mem [4] = '{2'd2, 2'd0, 2'd3, 2'd1};

  exp_t q[$];
  int   tests = 0, fails = 0;
  int   done_cnt = 0, rst_cnt = 0, rises = 0, busy_cnt = 0, on_run = 0;
  logic [3:0] prev_led = '0;

  playback_sequencer #(
    .LOAD_W(LOAD_W), .ON_LOAD(LOAD_W'(ON_L)), .OFF_LOAD(LOAD_W'(OFF_L)), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .pat_addr(pat_addr), .pat_data(pat_data),
    .tmr_load(tmr_load), .tmr_reset(tmr_reset), .tmr_enable(tmr_enable),
    .tmr_pulse(tmr_pulse), .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign pat_data  = mem[pat_addr[1:0]];
  // Timer fires while its count sits at 1, so the pulse lands LOAD cycles after the reload.
  assign tmr_pulse = (tmr_enable && !tmr_reset && cnt == LOAD_W'(1)) || force_pulse;

  always_ff @(posedge clk) begin
    if (tmr_reset) cnt <= tmr_load;
    else if (tmr_enable && cnt != '0) cnt <= cnt - 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard at each LED turn-on and checks ON duration.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (tmr_reset) rst_cnt++;
      if (busy) busy_cnt++;
      if (led != 4'b0 && prev_led == 4'b0) begin
        rises++;
        if (q.size() == 0) check("unexpected_led", {28'b0, led}, 32'b0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("led", {28'b0, led}, {28'b0, e.led});
          check("pat_addr", {28'b0, pat_addr}, {28'b0, e.addr});
        end
      end
      if (led != 4'b0) on_run++;
      else if (prev_led != 4'b0) begin
        check("on_cycles", on_run, ON_L);
        on_run = 0;
      end
      prev_led = led;
    end else begin
      prev_led = '0;
      on_run   = 0;
    end
  end

  task automatic push_exp(input int n);
    int m;
    m = (n > MAXL) ? MAXL : n;
    for (int i = 0; i < m; i++) begin
      exp_t e;
      e.led  = color_onehot(color_t'(mem[i % 4]));
      e.addr = AW'(i);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start  = 1'b1;
    length = (AW+1)'(n);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    for (int n = 0; n < budget && done_cnt == base; n++) @(negedge clk);
    check("done_timeout", done_cnt > base, 1);
  endtask

  task automatic run_play(input string tag, input int n, input int exp_elems, input int exp_arms);
    int db, rb, eb;
    db = done_cnt; rb = rst_cnt; eb = rises;
    push_exp(n);
    pulse_start(n);
    check({tag, "_busy_e1"}, busy, 1);
    wait_done(db, 400);
    repeat (3) @(negedge clk);
    check({tag, "_elems"}, rises - eb, exp_elems);
    check({tag, "_dones"}, done_cnt - db, 1);
    check({tag, "_arms"}, rst_cnt - rb, exp_arms);
    check({tag, "_q_empty"}, q.size(), 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_en_end"}, tmr_enable, 0);
  endtask

  initial begin
    int db, bb, rb, eb;
    repeat (3) @(negedge clk);
    check("rst_led", {28'b0, led}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", tmr_enable, 0);
    check("rst_treset", tmr_reset, 0);
    check("rst_load", tmr_load, 0);
    check("rst_addr", {28'b0, pat_addr}, 0);
    reset = 1'b0;

    // Four elements in order {2,0,3,1}; last element has no OFF arm.
    run_play("len4", 4, 4, 7);
    check("load_hold", tmr_load, ON_L);

    // Zero length: done straight after E, nothing else moves.
    db = done_cnt; bb = busy_cnt; rb = rst_cnt;
    pulse_start(0);
    check("len0_done_e1", done, 1);
    check("len0_busy_e1", busy, 0);
    @(negedge clk);
    check("len0_done_once", done, 0);
    repeat (3) @(negedge clk);
    check("len0_busy_never", busy_cnt - bb, 0);
    check("len0_treset", rst_cnt - rb, 0);
    check("len0_led", {28'b0, led}, 0);
    check("len0_dones", done_cnt - db, 1);

    // Oversized length clamps to MAX_LEN.
    run_play("len20", 20, 16, 31);

    // Second start during SHOW of element 1 is ignored.
    db = done_cnt; eb = rises;
    push_exp(4);
    pulse_start(4);
    for (int n = 0; n < 100 && rises - eb < 2; n++) @(negedge clk);
    check("dbl_reach_show1", rises - eb, 2);
    pulse_start(2);
    wait_done(db, 400);
    repeat (3) @(negedge clk);
    check("dbl_elems", rises - eb, 4);
    check("dbl_dones", done_cnt - db, 1);
    check("dbl_q_empty", q.size(), 0);

    // Reset during GAP of element 2, then replay from element 0.
    db = done_cnt; eb = rises;
    push_exp(4);
    pulse_start(4);
    for (int n = 0; n < 100 && rises - eb < 3; n++) @(negedge clk);
    for (int n = 0; n < 20 && !(led == 4'b0 && tmr_reset); n++) @(negedge clk);
    check("gap_reached", tmr_reset && busy && led == 4'b0, 1);
    @(negedge clk);  // now in GAP
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    check("mid_rst_led", {28'b0, led}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_en", tmr_enable, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", done_cnt - db, 0);
    run_play("replay", 4, 4, 7);

    // Spurious pulse held in IDLE, ARM_ON and ARM_OFF must not advance the FSM.
    force_pulse = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pulse_busy", busy, 0);
    check("idle_pulse_led", {28'b0, led}, 0);
    db = done_cnt; eb = rises;
    push_exp(2);
    pulse_start(2);  // returns in ARM_ON with the pulse still forced
    check("arm_on_treset", tmr_reset, 1);
    @(negedge clk);
    force_pulse = 1'b0;
    check("arm_on_to_show", {28'b0, led}, {28'b0, color_onehot(BLUE)});
    for (int n = 0; n < 20 && !(led == 4'b0 && tmr_reset); n++) @(negedge clk);
    force_pulse = 1'b1;
    @(negedge clk);
    force_pulse = 1'b0;
    check("arm_off_to_gap", busy && led == 4'b0 && !done, 1);
    wait_done(db, 200);
    repeat (3) @(negedge clk);
    check("spur_elems", rises - eb, 2);
    check("spur_dones", done_cnt - db, 1);
    check("spur_q_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Sequences the shared countdown timer to play a stored Simon colour pattern on the four LEDs. Each element lights one LED for a programmable ON period, followed by an OFF gap. The block arms the timer by driving its load value, reset and enable, and it advances on the timer's pulse. It sits between the game-control FSM (start/done) and the pattern memory, and it owns the timer whenever it is busy.

## Interface
Parameters:
- LOAD_W, 25, width of the timer load value
- ON_LOAD, 25'd12_500_000, timer load for the LED-on phase
- OFF_LOAD, 25'd6_250_000, timer load for the inter-element gap
- MAX_LEN, 16, pattern memory depth; ADDR_W = $clog2(MAX_LEN)

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to play elements 0..length-1
- length  in  ADDR_W+1  number of elements to play; sampled with start
- pat_addr  out  ADDR_W  pattern memory address
- pat_data  in  2  colour at pat_addr; combinational read, valid in the same cycle
- tmr_load  out  LOAD_W  timer load value
- tmr_reset  out  1  timer reload strobe
- tmr_enable  out  1  timer count enable
- tmr_pulse  in  1  timer expiry
- led  out  4  one-hot LED drive; colour c lights led[c]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ARM_ON, SHOW, ARM_OFF, GAP, DONE.
- IDLE: led=0, tmr_enable=0, busy=0.
  - start=1 latches len = min(length, MAX_LEN) and clears idx.
  - If len==0, go to DONE. Otherwise go to ARM_ON.
- ARM_ON (1 cycle): tmr_load=ON_LOAD, tmr_reset=1, tmr_enable=1, pat_addr=idx. Register the colour from pat_data. Go to SHOW.
- SHOW: led=onehot(colour), tmr_enable=1, tmr_reset=0.
  - On tmr_pulse=1: if idx==len-1, go to DONE; else go to ARM_OFF.
- ARM_OFF (1 cycle): tmr_load=OFF_LOAD, tmr_reset=1, led=0, idx++. Go to GAP.
- GAP: led=0, tmr_enable=1. On tmr_pulse=1, go to ARM_ON.
- DONE (1 cycle): done=1, led=0, tmr_enable=0. Go to IDLE.
- tmr_pulse is ignored in every state except SHOW and GAP.
- tmr_load holds its last driven value outside the ARM states. tmr_reset=0 outside the ARM states.
- start while busy: ignored. No queueing.
- length>MAX_LEN: clamped to MAX_LEN.
- idx is ADDR_W+1 bits wide, so it never wraps before the len comparison.
- Colour encoding comes from the package: 0 red, 1 green, 2 blue, 3 yellow.

## Timing
- All outputs are registered.
- Reset values: led=0, busy=0, done=0, tmr_enable=0, tmr_reset=0, tmr_load=0, pat_addr=0, state=IDLE.
- Start sampled at edge E:
  - E+1: ARM_ON with busy=1.
  - E+2: first led on.
- Element-to-element cost: 2 arm cycles plus the timer period of each phase.
- Pulse sampled at edge P in SHOW: led=0 from P+1.
  - For the last element, done=1 from P+1 for one cycle and busy=0 from P+2.
- len==0: done at E+1, busy never asserts, timer untouched.
- Reset mid-operation: at the next edge, state=IDLE with all outputs at reset values. No done pulse.
- Reset and start in the same cycle: reset wins.

## Structure
- Shared package simon_pkg holds:
  - the colour enum (2 bits) and the onehot colour-to-LED function
  - the state enum for this FSM
  - the ON_LOAD/OFF_LOAD defaults, so game control and input-timeout logic use the same values
- No sub-module. The timer stays a peer instance wired at top level; the sequencer only drives its controls.

## Test plan
All scenarios use ON_LOAD=3, OFF_LOAD=2 with a behavioural timer and memory model holding {2,0,3,1}.
- start with length=4 → led sequence 0100, 0001, 1000, 0010 with gaps of led=0; pat_addr steps 0..3; single done after the last SHOW; 2 ARM pulses of tmr_reset per element (1 for the last).
- start with length=0 → done at E+1; busy, led, tmr_reset all stay 0.
- start with length=20 (MAX_LEN=16) → exactly 16 elements shown, then done.
- second start pulsed during SHOW of element 1 → ignored; exactly 4 elements played, one done.
- reset asserted during GAP of element 2 → next cycle led=0, busy=0, tmr_enable=0, no done; a later start replays from element 0.
- spurious tmr_pulse held high in IDLE and in ARM cycles → no state change. Led-on duration equals the ON timer period, measured in cycles.
